// File: rtl/cmos_pkg.sv
// cmos_pkg: shared types for the pixel readout path
package cmos_pkg;
    localparam int PIX_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;
    typedef struct packed {
        logic [PIX_W_DEF-1:0] p1;
        logic [PIX_W_DEF-1:0] p2;
    } pix_pair_t;
endpackage

// File: rtl/pix_pair_fifo.sv
// pix_pair_fifo: synchronous first-word-fall-through FIFO of pixel pairs
module pix_pair_fifo
    import cmos_pkg::*;
#(
    parameter type T     = pix_pair_t,
    parameter int  DEPTH = 4
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  T                         i_data,
    output T                         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wp, r_rp;
    logic [AW:0]    r_cnt;
    logic           w_push, w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rp];
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: reads pixel pairs from the memory handler and
// serializes them as a valid/ready byte stream, one frame per start pulse
module pixel_readout_ctrl
    import cmos_pkg::*;
#(
    parameter int PIX_W      = PIX_W_DEF,
    parameter int N_ROWS     = 16,
    parameter int FIFO_DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       frame_reset,
    input  logic                       start,
    output logic                       read,
    input  logic [$clog2(N_ROWS)-1:0]  read_select,
    input  logic [PIX_W-1:0]           pixelDataOut1,
    input  logic [PIX_W-1:0]           pixelDataOut2,
    output logic [PIX_W-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       seq_err
);
    localparam int RW = $clog2(N_ROWS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    typedef struct packed {
        logic [PIX_W-1:0] p1;
        logic [PIX_W-1:0] p2;
    } pair_t;
    rd_state_t    r_state;
    logic         r_read, r_busy, r_done, r_seq_err, r_ser_valid, r_phase;
    logic [RW-1:0] r_row, r_pops, r_out_row;
    pair_t        r_pair, w_fifo_in, w_fifo_out;
    logic         w_fifo_full, w_fifo_empty, w_pop, w_last_cap, w_read_next;
    logic [CW-1:0] w_count, w_count_next;
    assign w_fifo_in = '{p1: pixelDataOut1, p2: pixelDataOut2};
    pix_pair_fifo #(.T(pair_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst   (frame_reset),
        .i_push  (r_read),
        .i_pop   (w_pop),
        .i_data  (w_fifo_in),
        .o_data  (w_fifo_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );
    // a new pair is loaded when the serializer is empty or its pixel2 is leaving
    assign w_pop        = !w_fifo_empty && (!r_ser_valid || (r_phase && out_ready));
    assign w_last_cap   = r_read && r_row == RW'(N_ROWS-1);
    assign w_count_next = w_count + CW'(r_read) - CW'(w_pop);
    // keep one slot spare so the capture already in flight always fits
    assign w_read_next  = !w_last_cap && !w_fifo_full && w_count_next <= CW'(FIFO_DEPTH-2);
    always_ff @(posedge clk) begin
        if (frame_reset) begin
            r_state   <= IDLE;
            r_read    <= 1'b0;
            r_row     <= '0;
            r_seq_err <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_read) begin
                r_row <= w_last_cap ? '0 : r_row + 1'b1;
                if (read_select != r_row) r_seq_err <= 1'b1;
            end
            case (r_state)
                IDLE: if (start) begin
                    r_state <= READ;
                    r_read  <= 1'b1;
                    r_busy  <= 1'b1;
                end
                READ: begin
                    r_read <= w_read_next;
                    if (w_last_cap) r_state <= DRAIN;
                end
                DRAIN: if (w_fifo_empty && !r_ser_valid) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE: r_state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (frame_reset) begin
            r_ser_valid <= 1'b0;
            r_phase     <= 1'b0;
            r_pops      <= '0;
            r_out_row   <= '0;
            r_pair      <= '0;
        end else if (w_pop) begin
            r_pair      <= w_fifo_out;
            r_phase     <= 1'b0;
            r_ser_valid <= 1'b1;
            r_out_row   <= r_pops;
            r_pops      <= r_pops == RW'(N_ROWS-1) ? '0 : r_pops + 1'b1;
        end else if (r_ser_valid && out_ready) begin
            r_phase     <= !r_phase;
            r_ser_valid <= !r_phase;
        end
    end
    assign read       = r_read;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign seq_err    = r_seq_err;
    assign out_valid  = r_ser_valid;
    assign out_data   = r_phase ? r_pair.p2 : r_pair.p1;
    assign out_last   = r_ser_valid && r_phase && r_out_row == RW'(N_ROWS-1);
endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// tb_pixel_readout_ctrl: scoreboard bench with a behavioural memory handler
module tb_pixel_readout_ctrl;
    logic       clk = 1'b0, frame_reset = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic       read, out_valid, out_last, busy, frame_done, seq_err;
    logic [3:0] read_select = 4'd0;
    logic [7:0] pix1, pix2, out_data, hold_d;
    logic [8:0] sb[$];
    logic [8:0] exp_b;
    logic       held = 1'b0, dmode = 1'b0, jump_en = 1'b0;
    int         n_chk = 0, n_fail = 0, n_done = 0;

    always #5 clk = ~clk;

    pixel_readout_ctrl dut (
        .clk(clk), .frame_reset(frame_reset), .start(start), .read(read),
        .read_select(read_select), .pixelDataOut1(pix1), .pixelDataOut2(pix2),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .frame_done(frame_done), .seq_err(seq_err)
    );

    // row r carries {A,r}/{5,r} in pattern mode, constant AA/FF otherwise
    function automatic logic [7:0] px(input logic m, input logic second, input logic [3:0] r);
        return m ? {(second ? 4'h5 : 4'hA), r} : (second ? 8'hFF : 8'hAA);
    endfunction

    assign pix1 = px(dmode, 1'b0, read_select);
    assign pix2 = px(dmode, 1'b1, read_select);

    always @(posedge clk) begin
        if (frame_reset) read_select <= 4'd0;
        else if (read) read_select <= read_select + ((jump_en && read_select == 4'd5) ? 4'd2 : 4'd1);
    end

    task automatic chk(input logic ok, input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (frame_reset) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) chk(out_valid && out_data == hold_d, "stall_hold", 32'({out_valid, out_data}), 32'({1'b1, hold_d}));
            held   = out_valid && !out_ready;
            hold_d = out_data;
            if (frame_done) n_done++;
            if (read) chk(!dut.u_fifo.o_full, "push_on_full", 32'(dut.u_fifo.o_count), 32'd3);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk(1'b0, "extra_byte", 32'({out_last, out_data}), 32'd0);
                else begin
                    exp_b = sb.pop_front();
                    chk({out_last, out_data} == exp_b, "byte", 32'({out_last, out_data}), 32'(exp_b));
                end
            end
        end
    end

    task automatic launch(input logic m);
        dmode = m;
        for (int r = 0; r < 16; r++) begin
            sb.push_back({1'b0, px(m, 1'b0, 4'(r))});
            sb.push_back({r == 15, px(m, 1'b1, 4'(r))});
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk(read, "start_to_read", 32'(read), 32'd1);
    endtask

    // kind: 0 ready high, 1 ten-cycle stall, 2 ready toggling, 3 extra start in READ
    task automatic run(input int kind, input logic exp_err);
        int d0 = n_done;
        int cyc = 0;
        while (n_done == d0 && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = kind == 1 ? !(cyc >= 20 && cyc < 30) : kind == 2 ? (cyc % 2 == 1) : 1'b1;
            start = kind == 3 && cyc == 5;
            if (cyc == 1) chk(!out_valid && busy, "first_valid_early", 32'({out_valid, busy}), 32'b01);
            if (cyc == 2) chk(out_valid, "first_valid_lat", 32'(out_valid), 32'd1);
            if (kind == 1 && cyc == 29) chk(!read, "stall_read_off", 32'(read), 32'd0);
        end
        chk(n_done != d0, "frame_timeout", 32'(cyc), 32'd600);
        out_ready = 1'b1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk(sb.size() == 0, "bytes_left", 32'(sb.size()), 32'd0);
        chk(n_done == d0 + 1, "frame_done_count", 32'(n_done - d0), 32'd1);
        chk(seq_err == exp_err, "seq_err", 32'(seq_err), 32'(exp_err));
        chk(!busy && !read && !out_valid, "idle_after", 32'({busy, read, out_valid}), 32'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk(!read && !out_valid && !busy && !frame_done && !seq_err && !out_last && out_data == 8'h00,
            "reset_outputs", 32'({read, out_valid, busy, frame_done, seq_err, out_last, out_data}), 32'd0);
        frame_reset = 1'b0;
        @(posedge clk); #1;
        launch(1'b0); run(0, 1'b0);
        launch(1'b1); run(1, 1'b0);
        jump_en = 1'b1;
        launch(1'b0); run(0, 1'b1);
        jump_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(seq_err, "seq_err_sticky", 32'(seq_err), 32'd1);
        frame_reset = 1'b1;
        @(posedge clk); #1;
        frame_reset = 1'b0;
        chk(!seq_err, "seq_err_clear", 32'(seq_err), 32'd0);
        launch(1'b1);
        k = 0;
        while (read_select != 4'd8 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk(read_select == 4'd8, "reach_row8", 32'(read_select), 32'd8);
        frame_reset = 1'b1;
        @(posedge clk); #1;
        frame_reset = 1'b0;
        chk(!read && !out_valid && !busy, "abort_idle", 32'({read, out_valid, busy}), 32'd0);
        launch(1'b1); run(0, 1'b0);
        launch(1'b1); run(3, 1'b0);
        launch(1'b1); run(2, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
